// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 16;

  // A depth-2 FIFO still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write port, combinational read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int depth = FIFO_DEPTH,
  parameter int width = FIFO_WIDTH,
  parameter int aw    = ptr_width(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem_reg [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock count-based FIFO with registered read data.
// Optional overflow/underflow pulse outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo
  import fifo_pkg::*;
#(
  parameter int depth = FIFO_DEPTH,
  parameter int width = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = ptr_width(depth);
  localparam int CW = count_width(depth);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [width-1:0] dout_reg;
  logic [width-1:0] mem_rdata;
  logic             wr_ok;
  logic             rd_ok;

  // Both requests are qualified by the pre-edge flags, so full+both reads only
  // and empty+both writes only (no fall-through to dout).
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(depth));
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = dout_reg;

  fifo_mem #(
    .depth (depth),
    .width (width),
    .aw    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (wr_ptr_reg),
    .wdata (din),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        dout_reg   <= mem_rdata;
      end
      if (wr_ok && !rd_ok) begin
        count_reg <= count_reg + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_en && full;
      underflow_reg <= rd_en && empty;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue-based reference model compared every cycle,
// plus directed literal checks. Handles builds with or without FIFO_ERR_FLAGS_EN.
module tb_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  int checks = 0;
  int errors = 0;

  fifo #(.depth(DEPTH), .width(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored words plus the last word read out.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_over;
  logic             m_under;
  bit               m_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after posedge, so at negedge they describe the upcoming edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_dout", dout, m_dout);
      check("cyc_empty", empty, q.size() == 0);
      check("cyc_full", full, q.size() == DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
      check("cyc_overflow", overflow, m_over);
      check("cyc_underflow", underflow, m_under);
`endif
    end
    if (rst) begin
      q.delete();
      m_dout  = '0;
      m_over  = 0;
      m_under = 0;
      m_valid = 1;
    end else if (m_valid) begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      m_over  = wr_en && was_full;
      m_under = rd_en && was_empty;
      if (rd_en && !was_empty) m_dout = q.pop_front();
      if (wr_en && !was_full) q.push_back(din);
    end
  end

  task automatic tick(input bit r, input bit w, input bit rd, input logic [WIDTH-1:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // 1. reset
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    check("reset_dout", dout, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);

    // 2. single write then read
    tick(0, 1, 0, 16'h1234);
    check("single_empty_after_wr", empty, 0);
    tick(0, 0, 1, '0);
    check("single_dout", dout, 16'h1234);
    check("single_empty_after_rd", empty, 1);

    // 3. fill, then rejected write
    for (int i = 1; i <= DEPTH; i++) begin
      tick(0, 1, 0, WIDTH'(i));
      check("fill_full", full, i == DEPTH);
    end
    tick(0, 1, 0, 16'hFFFF);
    check("overfill_full", full, 1);
`ifdef FIFO_ERR_FLAGS_EN
    check("overfill_overflow", overflow, 1);
`endif

    // 4. drain, then rejected read
    for (int i = 1; i <= DEPTH; i++) begin
      tick(0, 0, 1, '0);
      check("drain_dout", dout, i);
    end
    check("drain_empty", empty, 1);
    tick(0, 0, 1, '0);
    check("underread_dout", dout, 16'h0008);
`ifdef FIFO_ERR_FLAGS_EN
    check("underread_underflow", underflow, 1);
`endif

    // 5. preload 4, then simultaneous read/write across wrap
    for (int i = 0; i < 4; i++) tick(0, 1, 0, WIDTH'(16'h0A00 + i));
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 1, WIDTH'(16'h0B00 + i));
      check("both_count", q.size(), 4);
      check("both_dout", dout, (i < 4) ? (16'h0A00 + i) : (16'h0B00 + i - 4));
    end
    for (int i = 0; i < 4; i++) tick(0, 1, 0, WIDTH'($urandom));
    check("prefull", full, 1);
    tick(0, 1, 1, 16'hCCCC);
    check("full_both_count", q.size(), DEPTH - 1);
    check("full_both_full", full, 0);
    while (!empty) tick(0, 0, 1, '0);
    tick(0, 1, 1, 16'hDDDD);
    check("empty_both_count", q.size(), 1);
    check("empty_both_empty", empty, 0);
    check("empty_both_no_fallthru", dout != 16'hDDDD, 1);
    tick(0, 0, 1, '0);
    check("empty_both_later_read", dout, 16'hDDDD);

    // 6. reset mid-operation
    for (int i = 0; i < 5; i++) tick(0, 1, 0, WIDTH'(16'h5000 + i));
    tick(1, 0, 0, '0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_dout", dout, 0);
    tick(0, 1, 0, 16'hBEEF);
    tick(0, 0, 1, '0);
    check("midrst_new_word", dout, 16'hBEEF);
    check("midrst_empty_after", empty, 1);

    // 7. randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 300) % 3;
      automatic bit w = ($urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50)));
      automatic bit r = ($urandom_range(99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50)));
      automatic bit rs = ($urandom_range(399) == 0);
      tick(rs, w, r, WIDTH'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
